mem_bus_arbiter: RTL and testbench

//  Shares the single-ported memory bus between two masters: the core (port C) and a debug/DMA master (port D).

---
 rtl/mem_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (core C, debug/DMA D) arbiter for a single-ported memory bus.
// Round-robin grant, one registered transaction at a time, optional wait-state timeout.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_c_req,
    input  logic        i_c_we,
    input  logic [31:0] i_c_addr,
    input  logic [31:0] i_c_wdata,
    input  logic [1:0]  i_c_width,
    output logic        o_c_done,
    output logic        o_c_err,

    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [1:0]  i_d_width,
    output logic        o_d_done,
    output logic        o_d_err,

    output logic [31:0] o_rd_data,

    output logic        o_m_req,
    output logic        o_m_we,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    output logic [1:0]  o_m_width,
    input  logic [31:0] i_m_rdata,
    input  logic        i_m_ack
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDTH_W = 2;
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] ERR_DATA = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner_d;
    logic                w_owner_d_nxt;
    logic                r_prio_d;
    logic                w_prio_d_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                r_m_req;
    logic                w_m_req_nxt;
    logic                r_m_we;
    logic                w_m_we_nxt;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [ADDR_W-1:0]   w_m_addr_nxt;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [DATA_W-1:0]   w_m_wdata_nxt;
    logic [WIDTH_W-1:0]  r_m_width;
    logic [WIDTH_W-1:0]  w_m_width_nxt;

    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   w_rd_data_nxt;
    logic                r_c_done;
    logic                w_c_done_nxt;
    logic                r_c_err;
    logic                w_c_err_nxt;
    logic                r_d_done;
    logic                w_d_done_nxt;
    logic                r_d_err;
    logic                w_d_err_nxt;

    logic                w_grant_d;
    logic                w_timeout;
    logic                w_finish;
    logic                w_finish_err;

    // D wins only when C is idle or when the pointer says D is owed the next tie.
    assign w_grant_d = i_d_req & (~i_c_req | r_prio_d);

    // Last permitted wait cycle with no ack; disabled entirely when TIMEOUT is zero.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_finish     = i_m_ack | w_timeout;
    assign w_finish_err = ~i_m_ack & w_timeout;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_d_nxt = r_owner_d;
        w_prio_d_nxt  = r_prio_d;
        w_cnt_nxt     = r_cnt;
        w_m_req_nxt   = r_m_req;
        w_m_we_nxt    = r_m_we;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_m_width_nxt = r_m_width;
        w_rd_data_nxt = r_rd_data;
        w_c_done_nxt  = 1'b0;
        w_c_err_nxt   = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_d_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_c_req || i_d_req) begin
                    w_owner_d_nxt = w_grant_d;
                    w_prio_d_nxt  = ~w_grant_d;
                    w_cnt_nxt     = '0;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = w_grant_d ? i_d_we    : i_c_we;
                    w_m_addr_nxt  = w_grant_d ? i_d_addr  : i_c_addr;
                    w_m_wdata_nxt = w_grant_d ? i_d_wdata : i_c_wdata;
                    w_m_width_nxt = w_grant_d ? i_d_width : i_c_width;
                    w_state_nxt   = S_XFER;
                end
            end

            S_XFER: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_finish) begin
                    w_rd_data_nxt = i_m_ack ? i_m_rdata : ERR_DATA;
                    w_m_req_nxt   = 1'b0;
                    w_c_done_nxt  = ~r_owner_d;
                    w_c_err_nxt   = ~r_owner_d & w_finish_err;
                    w_d_done_nxt  = r_owner_d;
                    w_d_err_nxt   = r_owner_d & w_finish_err;
                    w_state_nxt   = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_prio_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_width <= '0;
            r_rd_data <= '0;
            r_c_done  <= 1'b0;
            r_c_err   <= 1'b0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner_d <= w_owner_d_nxt;
            r_prio_d  <= w_prio_d_nxt;
            r_cnt     <= w_cnt_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_m_width <= w_m_width_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_c_done  <= w_c_done_nxt;
            r_c_err   <= w_c_err_nxt;
            r_d_done  <= w_d_done_nxt;
            r_d_err   <= w_d_err_nxt;
        end
    end

    assign o_m_req   = r_m_req;
    assign o_m_we    = r_m_we;
    assign o_m_addr  = r_m_addr;
    assign o_m_wdata = r_m_wdata;
    assign o_m_width = r_m_width;
    assign o_rd_data = r_rd_data;
    assign o_c_done  = r_c_done;
    assign o_c_err   = r_c_err;
    assign o_d_done  = r_d_done;
    assign o_d_err   = r_d_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle on a TIMEOUT=16
// instance, directed scenarios with literal expectations, and a TIMEOUT=4 instance.
module tb_mem_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;

    logic        c_req, c_we, d_req, d_we, m_ack;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
    logic [1:0]  c_width, d_width;
    logic        c_done, c_err, d_done, d_err;
    logic        m_req, m_we;
    logic [31:0] rd_data, m_addr, m_wdata;
    logic [1:0]  m_width;

    // Second instance, TIMEOUT=4, core port only
    logic        t_c_req, t_c_we, t_m_ack;
    logic [31:0] t_c_addr, t_c_wdata, t_m_rdata;
    logic [1:0]  t_c_width;
    logic        t_d_req = 1'b0, t_d_we = 1'b0;
    logic [31:0] t_d_addr = '0, t_d_wdata = '0;
    logic [1:0]  t_d_width = '0;
    logic        t_c_done, t_c_err, t_d_done, t_d_err;
    logic        t_m_req, t_m_we;
    logic [31:0] t_rd_data, t_m_addr, t_m_wdata;
    logic [1:0]  t_m_width;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .i_c_width(c_width), .o_c_done(c_done), .o_c_err(c_err),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_width(d_width), .o_d_done(d_done), .o_d_err(d_err),
        .o_rd_data(rd_data),
        .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .o_m_width(m_width), .i_m_rdata(m_rdata), .i_m_ack(m_ack)
    );

    mem_bus_arbiter #(.TIMEOUT(4)) u_dut4 (
        .i_clk(clk), .i_reset(reset),
        .i_c_req(t_c_req), .i_c_we(t_c_we), .i_c_addr(t_c_addr), .i_c_wdata(t_c_wdata),
        .i_c_width(t_c_width), .o_c_done(t_c_done), .o_c_err(t_c_err),
        .i_d_req(t_d_req), .i_d_we(t_d_we), .i_d_addr(t_d_addr), .i_d_wdata(t_d_wdata),
        .i_d_width(t_d_width), .o_d_done(t_d_done), .o_d_err(t_d_err),
        .o_rd_data(t_rd_data),
        .o_m_req(t_m_req), .o_m_we(t_m_we), .o_m_addr(t_m_addr), .o_m_wdata(t_m_wdata),
        .o_m_width(t_m_width), .i_m_rdata(t_m_rdata), .i_m_ack(t_m_ack)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a command is either absent, in flight (aged in wait cycles),
    // or in its one-cycle completion slot.
    bit          md_busy, md_cpl, md_owner_d, md_prio_d;
    int          md_age;
    logic        e_m_req, e_we, e_cd, e_ce, e_dd, e_de;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [1:0]  e_width;

    task automatic model_complete(input bit err, input logic [31:0] data);
        md_busy = 1'b0;
        md_cpl  = 1'b1;
        e_m_req = 1'b0;
        e_rd    = data;
        if (md_owner_d) begin e_dd = 1'b1; e_de = err; end
        else            begin e_cd = 1'b1; e_ce = err; end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            md_busy = 1'b0; md_cpl = 1'b0; md_prio_d = 1'b0; md_owner_d = 1'b0; md_age = 0;
            e_m_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_width = '0; e_rd = '0;
            e_cd = 1'b0; e_ce = 1'b0; e_dd = 1'b0; e_de = 1'b0;
        end else begin
            e_cd = 1'b0; e_ce = 1'b0; e_dd = 1'b0; e_de = 1'b0;
            if (md_cpl) begin
                md_cpl = 1'b0;
            end else if (md_busy) begin
                md_age = md_age + 1;
                if (m_ack)               model_complete(1'b0, m_rdata);
                else if (md_age == TO)   model_complete(1'b1, 32'hFFFF_FFFF);
            end else if (c_req || d_req) begin
                md_owner_d = d_req && (!c_req || md_prio_d);
                md_prio_d  = !md_owner_d;
                md_busy    = 1'b1;
                md_age     = 0;
                e_m_req    = 1'b1;
                e_we       = md_owner_d ? d_we    : c_we;
                e_addr     = md_owner_d ? d_addr  : c_addr;
                e_wdata    = md_owner_d ? d_wdata : c_wdata;
                e_width    = md_owner_d ? d_width : c_width;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_req", 72'(m_req), 72'(e_m_req));
            if (e_m_req)
                check("m_cmd", 72'({m_we, m_width, m_addr, m_wdata}),
                               72'({e_we, e_width, e_addr, e_wdata}));
            check("c_done", 72'(c_done), 72'(e_cd));
            check("c_err",  72'(c_err),  72'(e_ce));
            check("d_done", 72'(d_done), 72'(e_dd));
            check("d_err",  72'(d_err),  72'(e_de));
            if (e_cd || e_dd)
                check("rd_data", 72'(rd_data), 72'(e_rd));
        end
    end

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6)      return int'($urandom_range(0, 3));
        else if (r < 8) return int'($urandom_range(4, 15));
        else            return int'($urandom_range(14, 18));
    endfunction

    task automatic random_phase(input int cycles);
        int mem_wait;
        mem_wait = -1;
        for (int i = 0; i < cycles; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (m_req) begin
                if (mem_wait < 0) mem_wait = pick_delay();
                if (mem_wait == 0) begin
                    m_ack = 1'b1; m_rdata = $urandom; mem_wait = -1;
                end else begin
                    m_ack = 1'b0; mem_wait--;
                end
            end else begin
                mem_wait = -1;
                m_ack    = ($urandom_range(0, 7) == 0);
                m_rdata  = $urandom;
            end
            if (c_done)                                      c_req = 1'b0;
            else if (!c_req && $urandom_range(0, 3) == 0)    c_req = 1'b1;
            if (d_done)                                      d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 3) == 0)    d_req = 1'b1;
            c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom; c_width = 2'($urandom_range(0, 2));
            d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_width = 2'($urandom_range(0, 2));
            step();
        end
        reset = 1'b0; c_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
        for (int i = 0; i < TO + 4; i++) step();
    endtask

    int who[4];
    int when[4];
    int n_dn;

    initial begin
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_width = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_width = '0;
        m_ack = 0; m_rdata = '0;
        t_c_req = 0; t_c_we = 0; t_c_addr = '0; t_c_wdata = '0; t_c_width = '0;
        t_m_ack = 0; t_m_rdata = '0;
        step();
        check("rst_outputs", 72'({m_req, m_we, m_width, c_done, c_err, d_done, d_err}), 72'(0));
        check("rst_buses",   72'({m_addr, m_wdata}), 72'(0));
        check("rst_rd_data", 72'(rd_data), 72'(0));
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        // Basic core read, ack in third bus cycle
        c_req = 1; c_we = 0; c_addr = 32'h100; c_width = 2'd2;
        step();
        check("t1_m_req_c1", 72'({m_req, m_addr}), 72'({1'b1, 32'h100}));
        step();
        check("t1_m_req_c2", 72'(m_req), 72'(1));
        step();
        check("t1_m_req_c3", 72'(m_req), 72'(1));
        m_ack = 1; m_rdata = 32'hDEAD_BEEF;
        step();
        m_ack = 0;
        check("t1_done", 72'({c_done, c_err, d_done, m_req}), 72'(4'b1000));
        check("t1_rd_data", 72'(rd_data), 72'(32'hDEAD_BEEF));
        c_req = 0;
        step();
        check("t1_after", 72'({c_done, m_req}), 72'(0));

        // Debug write held through five wait cycles while its inputs wander
        d_req = 1; d_we = 1; d_addr = 32'h2003; d_wdata = 32'h1234_5678; d_width = 2'd0;
        step();
        for (int k = 1; k <= 5; k++) begin
            check("t3_cmd", 72'({m_req, m_we, m_width, m_addr, m_wdata}),
                            72'({1'b1, 1'b1, 2'd0, 32'h2003, 32'h1234_5678}));
            d_we = 0; d_addr = $urandom; d_wdata = $urandom; d_width = 2'd2;
            m_ack = (k == 5); m_rdata = 32'hA5A5_0003;
            step();
        end
        m_ack = 0;
        check("t3_done", 72'({d_done, d_err, c_done, m_req}), 72'(4'b1000));
        check("t3_rd_data", 72'(rd_data), 72'(32'hA5A5_0003));
        d_req = 0;
        step();

        // Reset during a debug transfer, then during a core transfer
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_width = 2'd2;
        step(); step();
        check("t6_d_xfer", 72'({m_req, m_addr}), 72'({1'b1, 32'h3000}));
        c_req = 1; c_we = 0; c_addr = 32'h4000; c_width = 2'd2;
        reset = 1; step(); reset = 0;
        check("t6_abort_d", 72'({m_req, d_done, c_done}), 72'(0));
        step();
        check("t6_c_first", 72'({m_req, m_addr}), 72'({1'b1, 32'h4000}));
        reset = 1; step(); reset = 0;
        check("t6_abort_c", 72'({m_req, d_done, c_done}), 72'(0));
        step();
        check("t6_c_again", 72'({m_req, m_addr}), 72'({1'b1, 32'h4000}));
        m_ack = 1; m_rdata = 32'h0000_4444;
        step();
        m_ack = 0;
        check("t6_c_done", 72'({c_done, d_done}), 72'(2'b10));
        c_req = 0;
        step(); step();
        check("t6_d_next", 72'({m_req, m_addr}), 72'({1'b1, 32'h3000}));
        m_ack = 1; step(); m_ack = 0;
        check("t6_d_done", 72'({d_done, c_done}), 72'(2'b10));
        d_req = 0;
        step();

        // Both masters held from reset, zero-wait memory: strict alternation
        c_req = 1; d_req = 1; c_addr = 32'hC0; d_addr = 32'hD0;
        reset = 1; step(); reset = 0;
        n_dn = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            m_ack = m_req; m_rdata = 32'h5000 + 32'(cyc);
            step();
            if ((c_done || d_done) && n_dn < 4) begin
                who[n_dn] = int'(d_done); when[n_dn] = cyc + 1; n_dn++;
            end
        end
        c_req = 0; d_req = 0; m_ack = 0;
        check("t2_count", 72'(n_dn), 72'(4));
        for (int i = 0; i < 4; i++) begin
            check("t2_owner", 72'(who[i]), 72'(i % 2));
            check("t2_when", 72'(when[i]), 72'(2 + 3 * i));
        end
        step();

        random_phase(4000);

        // TIMEOUT=4 instance: no ack at all
        t_c_req = 1; t_c_we = 0; t_c_addr = 32'h500; t_c_width = 2'd2;
        step();
        for (int k = 1; k <= 4; k++) begin
            check("t4_m_req", 72'(t_m_req), 72'(1));
            step();
        end
        check("t4_timeout", 72'({t_m_req, t_c_done, t_c_err, t_d_done}), 72'(4'b0110));
        check("t4_rd_data", 72'(t_rd_data), 72'(32'hFFFF_FFFF));
        t_c_req = 0;
        step();
        check("t4_idle", 72'({t_m_req, t_c_done, t_c_err}), 72'(0));

        // TIMEOUT=4 instance: ack in the last allowed cycle wins
        t_c_req = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            check("t5_m_req", 72'(t_m_req), 72'(1));
            t_m_ack = (k == 4); t_m_rdata = 32'hCAFE_F00D;
            step();
        end
        t_m_ack = 0;
        check("t5_done", 72'({t_m_req, t_c_done, t_c_err}), 72'(3'b010));
        check("t5_rd_data", 72'(t_rd_data), 72'(32'hCAFE_F00D));
        t_c_req = 0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
